// File: rtl/multi_timer_if.sv
// CPU-facing register bus and interrupt outputs of the multi-channel timer.
// The slave modport is the timer's view; the master modport is the CPU's.
interface multi_timer_if #(
  parameter int CH = 2
);
  logic [31:0]   DEV_Addr;
  logic          DEV_WE;
  logic [31:0]   DEV_WD;
  logic [31:0]   DEV_RD;
  logic          intrp;
  logic [CH-1:0] intrp_vec;

  modport master (
    output DEV_Addr, DEV_WE, DEV_WD,
    input  DEV_RD, intrp, intrp_vec
  );

  modport slave (
    input  DEV_Addr, DEV_WE, DEV_WD,
    output DEV_RD, intrp, intrp_vec
  );
endinterface

// File: rtl/multi_timer.sv
// CH independent down-counting timers. Each timer has a CTRL/PRESET/COUNT/STATUS
// register bank and a four-state IDLE/LOAD/CNT/INT sequencer.
module multi_timer #(
  parameter int CH = 2,
  parameter int W  = 32
) (
  input  logic         clk,
  input  logic         reset,
  multi_timer_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_CNT  = 2'd2;
  localparam logic [1:0] S_INT  = 2'd3;

  localparam logic [1:0] R_CTRL   = 2'd0;
  localparam logic [1:0] R_PRESET = 2'd1;
  localparam logic [1:0] R_COUNT  = 2'd2;
  localparam logic [1:0] R_STATUS = 2'd3;

  logic [2:0]    ch_sel;
  logic [1:0]    reg_sel;
  logic [31:0]   ch_rd [CH];
  logic [CH-1:0] irq_vec;
  logic [31:0]   rd_data;
  logic          unused_addr;

  assign ch_sel      = bus.DEV_Addr[6:4];
  assign reg_sel     = bus.DEV_Addr[3:2];
  assign unused_addr = ^{bus.DEV_Addr[31:7], bus.DEV_Addr[1:0]};

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic         en_q, en_d;
    logic [1:0]   mode_q, mode_d;
    logic         im_q, im_d;
    logic         pend_q, pend_d;
    logic [1:0]   state_q, state_d;
    logic [W-1:0] preset_q, preset_d;
    logic [W-1:0] count_q, count_d;
    logic         wr_hit;
    logic [31:0]  rd_val;

    assign wr_hit = bus.DEV_WE && (ch_sel == 3'(c));

    always_comb begin
      // NOTE: every _d defaults to its _q first, so no path through this block can infer a latch.
      en_d     = en_q;
      mode_d   = mode_q;
      im_d     = im_q;
      pend_d   = pend_q;
      state_d  = state_q;
      preset_d = preset_q;
      count_d  = count_q;

      // The clear is applied before the sequencer so an INT on the same edge re-sets PEND.
      if (wr_hit && reg_sel == R_STATUS && bus.DEV_WD[0]) pend_d = 1'b0;

      case (state_q)
        S_IDLE: if (en_q) state_d = S_LOAD;
        S_LOAD: begin
          count_d = preset_q;
          state_d = S_CNT;
        end
        S_CNT: begin
          if (!en_q) begin
            state_d = S_IDLE;
          end else if (count_q == '0) begin
            state_d = S_INT;
          end else begin
            count_d = count_q - W'(1);
            if (count_q == W'(1)) state_d = S_INT;
          end
        end
        default: begin
          pend_d = 1'b1;
          if (mode_q == 2'b01) begin
            state_d = S_LOAD;
          end else begin
            en_d    = 1'b0;
            state_d = S_IDLE;
          end
        end
      endcase

      // CPU writes come last so they override the one-shot EN auto-clear.
      if (wr_hit && reg_sel == R_CTRL) begin
        en_d   = bus.DEV_WD[0];
        mode_d = bus.DEV_WD[2:1];
        im_d   = bus.DEV_WD[3];
      end
      if (wr_hit && reg_sel == R_PRESET) preset_d = bus.DEV_WD[W-1:0];
    end

    always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
        en_q     <= 1'b0;
        mode_q   <= 2'b00;
        im_q     <= 1'b0;
        pend_q   <= 1'b0;
        state_q  <= S_IDLE;
        preset_q <= '0;
        count_q  <= '0;
      end else begin
        en_q     <= en_d;
        mode_q   <= mode_d;
        im_q     <= im_d;
        pend_q   <= pend_d;
        state_q  <= state_d;
        preset_q <= preset_d;
        count_q  <= count_d;
      end
    end

    always_comb begin
      rd_val = '0;
      case (reg_sel)
        R_CTRL:   rd_val = {28'd0, im_q, mode_q, en_q};
        R_PRESET: rd_val = 32'(preset_q);
        R_COUNT:  rd_val = 32'(count_q);
        default:  rd_val = {29'd0, state_q, pend_q};
      endcase
    end

    assign ch_rd[c]   = rd_val;
    assign irq_vec[c] = pend_q & im_q;
  end

  // Channel indices with no timer behind them read as zero.
  always_comb begin
    rd_data = '0;
    for (int c = 0; c < CH; c++) begin
      if (ch_sel == 3'(c)) rd_data = ch_rd[c];
    end
  end

  assign bus.DEV_RD    = rd_data;
  assign bus.intrp_vec = irq_vec;
  assign bus.intrp     = |irq_vec;

endmodule
